// File: rtl/riscv_pkg.sv
// Shared types for the rv32i pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // Where the EX-stage ALU takes an operand from
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             is_load;
  } pipe_slot_t;

  localparam pipe_slot_t SLOT_EMPTY = '{valid: 1'b0, rd: REG_ZERO, we: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_fwd_select.sv
// Picks the forwarding source for one ID source register.
// Latency: combinational.
// Backpressure: none; the caller gates the result with bubbles.
module fwd_select
  import riscv_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  pipe_slot_t       ex_slot,
  input  pipe_slot_t       mem_slot,
  output fwd_sel_t         sel
);

  // Nearer producer wins; a load in EX cannot forward yet (load-use stall covers it)
  always_comb begin
    sel = FWD_RF;
    if (used && src != REG_ZERO) begin
      if (ex_slot.valid && ex_slot.we && !ex_slot.is_load && ex_slot.rd == src) begin
        sel = FWD_EXMEM;
      end else if (mem_slot.valid && mem_slot.we && mem_slot.rd == src) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller: forwarding selects, load-use stall, branch flush, perf counters.
// Latency: stall/bubble/flush combinational; fwd selects registered (valid while instr is in EX).
// Backpressure: stall_o holds PC and IF/ID one cycle per load-use; taken branch overrides it.
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_AW = REG_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_we_i,
  input  logic              id_is_load_i,
  input  logic              ex_branch_taken_i,
  output fwd_sel_t          fwd_a_o,
  output fwd_sel_t          fwd_b_o,
  output logic              stall_o,
  output logic              bubble_ex_o,
  output logic              flush_id_o,
  output logic [CNT_W-1:0]  cnt_stall_o,
  output logic [CNT_W-1:0]  cnt_flush_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pipe_slot_t ex_slot;
  pipe_slot_t mem_slot;
  pipe_slot_t wb_slot;
  fwd_sel_t   fwd_a_d;
  fwd_sel_t   fwd_b_d;
  logic       load_use;

  fwd_select u_fwd_a (
    .src      (id_rs1_i),
    .used     (id_uses_rs1_i),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .sel      (fwd_a_d)
  );

  fwd_select u_fwd_b (
    .src      (id_rs2_i),
    .used     (id_uses_rs2_i),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .sel      (fwd_b_d)
  );

  // Load in EX whose result a real ID instruction needs before it exists
  always_comb begin
    load_use = 1'b0;
    if (id_valid_i && ex_slot.valid && ex_slot.is_load && ex_slot.rd != REG_ZERO) begin
      load_use = (id_uses_rs1_i && id_rs1_i == ex_slot.rd) ||
                 (id_uses_rs2_i && id_rs2_i == ex_slot.rd);
    end
  end

  // A taken branch squashes the ID instruction, so any stall for it is moot
  assign flush_id_o  = ex_branch_taken_i;
  assign stall_o     = load_use && !ex_branch_taken_i;
  assign bubble_ex_o = load_use || ex_branch_taken_i;

  // Advance the slot pipeline and register the selects for the instruction entering EX
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_slot  <= SLOT_EMPTY;
      mem_slot <= SLOT_EMPTY;
      wb_slot  <= SLOT_EMPTY;
      fwd_a_o  <= FWD_RF;
      fwd_b_o  <= FWD_RF;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      if (bubble_ex_o || !id_valid_i) begin
        ex_slot <= SLOT_EMPTY;
        fwd_a_o <= FWD_RF;
        fwd_b_o <= FWD_RF;
      end else begin
        ex_slot <= '{valid: 1'b1, rd: id_rd_i, we: id_we_i, is_load: id_is_load_i};
        fwd_a_o <= fwd_a_d;
        fwd_b_o <= fwd_b_d;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_stall_o <= '0;
      cnt_flush_o <= '0;
    end else begin
      if (stall_o && cnt_stall_o != CNT_MAX) cnt_stall_o <= cnt_stall_o + 1'b1;
      if (flush_id_o && cnt_flush_o != CNT_MAX) cnt_flush_o <= cnt_flush_o + 1'b1;
    end
  end

  // A retiring load that targets a real register must be writing it back
  wb_load_writes : assert property (@(posedge clk_i) disable iff (rst_i)
    (wb_slot.valid && wb_slot.is_load && wb_slot.rd != REG_ZERO) |-> wb_slot.we);

endmodule
